// File: rtl/gb_fb_writer_if.sv
// Framebuffer write port shared between the pixel writer and the framebuffer.
// The writer side drives the request, address and data. The framebuffer side
// answers with ready.
interface gb_fb_writer_if;
    logic        fb_wr_en;
    logic [14:0] fb_wr_addr;
    logic [11:0] fb_wr_data;
    logic        fb_wr_ready;

    modport master (
        output fb_wr_en,
        output fb_wr_addr,
        output fb_wr_data,
        input  fb_wr_ready
    );

    modport slave (
        input  fb_wr_en,
        input  fb_wr_addr,
        input  fb_wr_data,
        output fb_wr_ready
    );
endinterface

// File: rtl/gb_fb_writer.sv
// Game Boy PPU pixel stream to linear RGB444 framebuffer writer.
// Pixels are mapped through a 4-entry palette and tagged with address y*H_PIX+x.
// They are queued in a small first-word-fall-through buffer that drains into a
// framebuffer write port. That port can stall.
// Line and frame geometry errors and buffer overflows are reported through
// sticky flags.
module gb_fb_writer #(
    parameter int          H_PIX      = 160,
    parameter int          V_PIX      = 144,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [11:0] PAL0       = 12'hFFF,
    parameter logic [11:0] PAL1       = 12'hAAA,
    parameter logic [11:0] PAL2       = 12'h555,
    parameter logic [11:0] PAL3       = 12'h000
) (
    input  logic                  fclk,
    input  logic                  fclk_rst_b,
    input  logic                  pix_valid,
    input  logic [1:0]            pix_shade,
    input  logic                  pix_hsync,
    input  logic                  pix_vsync,
    gb_fb_writer_if.master        fb,
    output logic                  frame_done,
    output logic                  err_overflow,
    output logic                  err_geom
);

    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_PIX + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [XW-1:0] H_MAX  = XW'(H_PIX);
    localparam logic [YW-1:0] V_MAX  = YW'(V_PIX);
    localparam logic [14:0]   H_STEP = 15'(H_PIX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [14:0]   base_q, base_d;
    logic          pend_q, pend_d;
    logic          eov_q, eov_d;
    logic          egeo_q, egeo_d;

    logic [14:0]   mem_addr [FIFO_DEPTH];
    logic [11:0]   mem_data [FIFO_DEPTH];
    logic [AW:0]   wptr_q, rptr_q;

    logic          fifo_empty, fifo_full, pop, push, push_req;
    logic [14:0]   push_addr;
    logic [11:0]   push_data;

    function automatic logic [11:0] shadeRgb(input logic [1:0] s);
        case (s)
            2'd0:    shadeRgb = PAL0;
            2'd1:    shadeRgb = PAL1;
            2'd2:    shadeRgb = PAL2;
            default: shadeRgb = PAL3;
        endcase
    endfunction

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop        = !fifo_empty && fb.fb_wr_ready;
    // A full buffer still accepts a pixel when its head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);

    // Outputs read as zero whenever nothing is queued, so stale slot contents never show.
    assign fb.fb_wr_en   = !fifo_empty;
    assign fb.fb_wr_addr = fifo_empty ? 15'd0 : mem_addr[rptr_q[AW-1:0]];
    assign fb.fb_wr_data = fifo_empty ? 12'd0 : mem_data[rptr_q[AW-1:0]];
    assign frame_done    = (state_q == S_DRAIN) && fifo_empty;
    assign err_overflow  = eov_q;
    assign err_geom      = egeo_q;

    // Next-state logic. Within a cycle, vsync is applied first, then the pixel, then hsync.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        base_d    = base_q;
        pend_d    = pend_q;
        egeo_d    = egeo_q;
        push_req  = 1'b0;
        push_addr = 15'd0;
        push_data = 12'd0;
        case (state_q)
            S_IDLE: begin
                if (pix_vsync) begin
                    state_d = S_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = 15'd0;
                end
            end
            S_ACTIVE: begin
                if (pix_vsync) begin
                    if (x_q != '0 || y_q != '0) egeo_d = 1'b1;
                    x_d    = '0;
                    y_d    = '0;
                    base_d = 15'd0;
                end
                if (pix_valid) begin
                    if (x_d < H_MAX) begin
                        push_req  = 1'b1;
                        push_addr = base_d + 15'(x_d);
                        push_data = shadeRgb(pix_shade);
                        x_d       = x_d + 1'b1;
                    end else begin
                        egeo_d = 1'b1;
                    end
                end
                if (pix_hsync) begin
                    if (x_d != H_MAX) egeo_d = 1'b1;
                    x_d    = '0;
                    y_d    = y_d + 1'b1;
                    base_d = base_d + H_STEP;
                    if (y_d == V_MAX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pix_valid) egeo_d = 1'b1;
                if (fifo_empty) begin
                    state_d = (pend_q || pix_vsync) ? S_ACTIVE : S_IDLE;
                    pend_d  = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = 15'd0;
                end else if (pix_vsync) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        eov_d = eov_q | (push_req && fifo_full && !pop);
    end

    // Control registers and buffer pointers. Reset empties the buffer immediately.
    always_ff @(posedge fclk) begin
        if (!fclk_rst_b) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= 15'd0;
            pend_q  <= 1'b0;
            eov_q   <= 1'b0;
            egeo_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            pend_q  <= pend_d;
            eov_q   <= eov_d;
            egeo_q  <= egeo_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Buffer storage. It needs no reset because the pointers decide what is valid.
    always_ff @(posedge fclk) begin
        if (push) begin
            mem_addr[wptr_q[AW-1:0]] <= push_addr;
            mem_data[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule
